// File: rtl/ifetch_refill_ctrl.sv
// Instruction-side refill controller: forwards cache hits to the fetch queue,
// or fetches a full line from instruction memory, writes it into the cache
// and bypasses it to the fetch queue. Redirects squash results, but any
// granted memory transaction is always drained to completion.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a fetch; hits are forwarded combinationally
// REQ   | memory request held until granted (or dropped on redirect)
// FILL  | collecting read beats into line_buf
// WRITE | single cycle: write line to cache, bypass it to the fetch queue
// DRAIN | squashed refill; absorb remaining beats, discard data
module ifetch_refill_ctrl #(
    parameter int DATA_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_req,
    input  logic [DATA_WIDTH-1:0]       fetch_addr,
    input  logic                        redirect,
    input  logic                        cache_hit,
    input  logic [CACHE_LINE_WIDTH-1:0] cache_rdata,
    output logic [CACHE_LINE_WIDTH-1:0] d_out,
    output logic                        d_out_valid,
    output logic                        fill_we,
    output logic [DATA_WIDTH-1:0]       fill_addr,
    output logic [CACHE_LINE_WIDTH-1:0] fill_data,
    output logic                        mem_req,
    output logic [DATA_WIDTH-1:0]       mem_addr,
    input  logic                        mem_gnt,
    input  logic                        mem_rvalid,
    input  logic [DATA_WIDTH-1:0]       mem_rdata,
    output logic                        busy,
    output logic [15:0]                 refill_count
);

    localparam int BEATS = CACHE_LINE_WIDTH / DATA_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] FILL  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DRAIN = 3'd4;

    logic [2:0]                  state;
    logic [CNT_W-1:0]            beat_cnt;
    logic [DATA_WIDTH-1:0]       line_addr;
    logic [CACHE_LINE_WIDTH-1:0] line_buf;

    // The offset-within-line bits of the fetch PC never matter for a line fetch.
    logic unused_addr_bits;
    assign unused_addr_bits = ^fetch_addr[3:0];

    // Sequencing FSM, beat collection and refill bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            line_addr    <= '0;
            line_buf     <= '0;
            refill_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fetch_req && !cache_hit && !redirect) begin
                        line_addr <= {fetch_addr[DATA_WIDTH-1:4], 4'b0000};
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (mem_gnt) begin
                        beat_cnt <= '0;
                        state    <= redirect ? DRAIN : FILL;
                    end else if (redirect) begin
                        state <= IDLE;
                    end
                end
                FILL: begin
                    if (mem_rvalid) begin
                        for (int i = 0; i < BEATS; i++) begin
                            if (beat_cnt == i[CNT_W-1:0]) begin
                                line_buf[i*DATA_WIDTH +: DATA_WIDTH] <= mem_rdata;
                            end
                        end
                        beat_cnt <= beat_cnt + 1'b1;
                        // A complete line is good data even if a redirect arrives with it.
                        if (beat_cnt == LAST_BEAT) begin
                            state        <= WRITE;
                            refill_count <= refill_count + 16'd1;
                        end else if (redirect) begin
                            state <= DRAIN;
                        end
                    end else if (redirect) begin
                        state <= DRAIN;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (mem_rvalid) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Output decode from the current state.
    always_comb begin
        d_out       = cache_rdata;
        d_out_valid = 1'b0;
        fill_we     = 1'b0;
        fill_addr   = '0;
        fill_data   = '0;
        mem_req     = 1'b0;
        mem_addr    = '0;
        case (state)
            IDLE: begin
                d_out_valid = !rst && fetch_req && cache_hit && !redirect;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = line_addr;
            end
            WRITE: begin
                fill_we     = 1'b1;
                fill_addr   = line_addr;
                fill_data   = line_buf;
                d_out       = line_buf;
                d_out_valid = fetch_req && !redirect;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ifetch_refill_ctrl.sv
// Directed bench for ifetch_refill_ctrl. Expected fetch-queue/cache-write
// events are queued by the stimulus; a monitor pops them whenever the DUT
// presents d_out_valid or fill_we.
module tb_ifetch_refill_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         fetch_req;
    logic [31:0]  fetch_addr;
    logic         redirect;
    logic         cache_hit;
    logic [127:0] cache_rdata;
    logic [127:0] d_out;
    logic         d_out_valid;
    logic         fill_we;
    logic [31:0]  fill_addr;
    logic [127:0] fill_data;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_gnt;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         busy;
    logic [15:0]  refill_count;

    always #5 clk = ~clk;

    ifetch_refill_ctrl #(.DATA_WIDTH(32), .CACHE_LINE_WIDTH(128)) dut (
        .clk(clk), .rst(rst),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .redirect(redirect),
        .cache_hit(cache_hit), .cache_rdata(cache_rdata),
        .d_out(d_out), .d_out_valid(d_out_valid),
        .fill_we(fill_we), .fill_addr(fill_addr), .fill_data(fill_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .busy(busy), .refill_count(refill_count)
    );

    typedef struct {
        logic [127:0] dout;
        logic         dv;
        logic         fwe;
        logic [31:0]  faddr;
        logic [127:0] fdata;
        logic [15:0]  rc;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [127:0] LINE_A = 128'h000000A3_000000A2_000000A1_000000A0;
    localparam logic [127:0] LINE_E = 128'h000000E3_000000E2_000000E1_000000E0;
    localparam logic [127:0] HIT_D  = 128'h44444444_33333333_22222222_11111111;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [127:0] dout, input logic dv, input logic fwe,
                            input logic [31:0] faddr, input logic [127:0] fdata,
                            input logic [15:0] rc);
        exp_t x;
        x.dout = dout; x.dv = dv; x.fwe = fwe; x.faddr = faddr; x.fdata = fdata; x.rc = rc;
        sb_q.push_back(x);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Monitor: every presented output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && (d_out_valid || fill_we)) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got d_out_valid=%0b fill_we=%0b expected no output",
                         d_out_valid, fill_we);
            end else begin
                e = sb_q.pop_front();
                check("sb_d_out_valid", {127'd0, d_out_valid}, {127'd0, e.dv});
                check("sb_fill_we", {127'd0, fill_we}, {127'd0, e.fwe});
                check("sb_d_out", d_out, e.dout);
                check("sb_refill_count", {112'd0, refill_count}, {112'd0, e.rc});
                if (e.fwe) begin
                    check("sb_fill_addr", {96'd0, fill_addr}, {96'd0, e.faddr});
                    check("sb_fill_data", fill_data, e.fdata);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; redirect = 1'b0; cache_hit = 1'b0;
        cache_rdata = 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // Reset state
        repeat (2) cyc();
        smp();
        check("rst_d_out_valid", {127'd0, d_out_valid}, 128'd0);
        check("rst_mem_req", {127'd0, mem_req}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_fill_we", {127'd0, fill_we}, 128'd0);
        check("rst_refill_count", {112'd0, refill_count}, 128'd0);
        check("rst_d_out", d_out, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF);
        cyc(); rst = 1'b0;

        // Hit: same-cycle forward
        cyc(); fetch_req = 1'b1; cache_hit = 1'b1; cache_rdata = HIT_D;
        push_exp(HIT_D, 1'b1, 1'b0, 32'h0, 128'h0, 16'd0);
        smp();
        check("hit_mem_req", {127'd0, mem_req}, 128'd0);
        check("hit_busy", {127'd0, busy}, 128'd0);

        // Miss with zero-wait grant and back-to-back beats
        cyc(); cache_hit = 1'b0; fetch_addr = 32'h0000_1234;
        cache_rdata = 128'h55555555_55555555_55555555_55555555;
        smp();
        check("miss_c_busy", {127'd0, busy}, 128'd0);
        cyc(); mem_gnt = 1'b1; smp();
        check("miss_mem_req", {127'd0, mem_req}, 128'd1);
        check("miss_mem_addr", {96'd0, mem_addr}, {96'd0, 32'h0000_1230});
        check("miss_busy", {127'd0, busy}, 128'd1);
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0; smp();
        check("miss_req_drop", {127'd0, mem_req}, 128'd0);
        cyc(); mem_rdata = 32'hA1;
        cyc(); mem_rdata = 32'hA2;
        cyc(); mem_rdata = 32'hA3;
        cyc(); mem_rvalid = 1'b0;
        push_exp(LINE_A, 1'b1, 1'b1, 32'h0000_1230, LINE_A, 16'd1);
        smp();
        check("write_busy", {127'd0, busy}, 128'd1);
        // Re-request right after WRITE hits in the refilled line
        cyc(); cache_hit = 1'b1; cache_rdata = LINE_A;
        push_exp(LINE_A, 1'b1, 1'b0, 32'h0, 128'h0, 16'd1);
        smp();
        check("after_write_busy", {127'd0, busy}, 128'd0);

        // Redirect in REQ with grant withheld
        cyc(); cache_hit = 1'b0; fetch_addr = 32'h0000_2008; smp();
        cyc(); fetch_req = 1'b0; smp();
        check("rdreq_mem_req", {127'd0, mem_req}, 128'd1);
        check("rdreq_mem_addr", {96'd0, mem_addr}, {96'd0, 32'h0000_2000});
        cyc(); redirect = 1'b1; smp();
        check("rdreq_mem_req_2", {127'd0, mem_req}, 128'd1);
        cyc(); redirect = 1'b0; smp();
        check("rdreq_req_drop", {127'd0, mem_req}, 128'd0);
        check("rdreq_idle", {127'd0, busy}, 128'd0);
        cyc(); smp();
        check("rdreq_count", {112'd0, refill_count}, {112'd0, 16'd1});

        // Redirect after beat 1: remaining beats absorbed
        cyc(); fetch_req = 1'b1; cache_hit = 1'b0; fetch_addr = 32'h0000_3000; smp();
        cyc(); fetch_req = 1'b0; mem_gnt = 1'b1; smp();
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hB0; smp();
        cyc(); mem_rvalid = 1'b0; redirect = 1'b1; fetch_req = 1'b1; cache_hit = 1'b1; smp();
        check("drain1_busy", {127'd0, busy}, 128'd1);
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hB1; smp();
        cyc(); redirect = 1'b0; mem_rdata = 32'hB2; smp();
        cyc(); fetch_req = 1'b0; mem_rdata = 32'hB3; smp();
        check("drain1_busy_last", {127'd0, busy}, 128'd1);
        cyc(); mem_rvalid = 1'b0; cache_hit = 1'b0; smp();
        check("drain1_idle", {127'd0, busy}, 128'd0);
        check("drain1_count", {112'd0, refill_count}, {112'd0, 16'd1});

        // Redirect coincident with grant
        cyc(); fetch_req = 1'b1; fetch_addr = 32'h0000_4000; smp();
        cyc(); fetch_req = 1'b0; mem_gnt = 1'b1; redirect = 1'b1; smp();
        check("drain2_mem_req", {127'd0, mem_req}, 128'd1);
        cyc(); mem_gnt = 1'b0; redirect = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hC0; smp();
        check("drain2_req_drop", {127'd0, mem_req}, 128'd0);
        check("drain2_busy", {127'd0, busy}, 128'd1);
        cyc(); mem_rdata = 32'hC1;
        cyc(); mem_rdata = 32'hC2;
        cyc(); mem_rdata = 32'hC3; smp();
        check("drain2_busy_last", {127'd0, busy}, 128'd1);
        cyc(); mem_rvalid = 1'b0; smp();
        check("drain2_idle", {127'd0, busy}, 128'd0);
        check("drain2_count", {112'd0, refill_count}, {112'd0, 16'd1});

        // Reset in FILL after two beats
        cyc(); fetch_req = 1'b1; fetch_addr = 32'h0000_5000; smp();
        cyc(); fetch_req = 1'b0; mem_gnt = 1'b1; smp();
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hD0;
        cyc(); mem_rdata = 32'hD1;
        cyc(); mem_rvalid = 1'b0; rst = 1'b1; smp();
        cyc(); rst = 1'b0; smp();
        check("rstfill_busy", {127'd0, busy}, 128'd0);
        check("rstfill_count", {112'd0, refill_count}, 128'd0);
        check("rstfill_mem_req", {127'd0, mem_req}, 128'd0);

        // Following miss: delayed grant, gapped beats, fetch queue no longer requesting
        cyc(); fetch_req = 1'b1; fetch_addr = 32'h0000_601C; smp();
        cyc(); fetch_req = 1'b0; smp();
        check("miss2_mem_req", {127'd0, mem_req}, 128'd1);
        check("miss2_mem_addr", {96'd0, mem_addr}, {96'd0, 32'h0000_6010});
        cyc(); mem_gnt = 1'b1; smp();
        cyc(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hE0; smp();
        cyc(); mem_rvalid = 1'b0; smp();
        cyc(); mem_rvalid = 1'b1; mem_rdata = 32'hE1;
        cyc(); mem_rdata = 32'hE2;
        cyc(); mem_rdata = 32'hE3;
        cyc(); mem_rvalid = 1'b0;
        push_exp(LINE_E, 1'b0, 1'b1, 32'h0000_6010, LINE_E, 16'd1);
        smp();
        check("miss2_write_busy", {127'd0, busy}, 128'd1);
        cyc(); smp();
        check("miss2_idle", {127'd0, busy}, 128'd0);

        repeat (2) cyc();
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
